// File: rtl/bitrev_reorder_reader.sv
// bitrev_reorder_reader: ping-pong reorder buffer. Samples are written in
// natural order into one bank while the other bank is read out in
// bit-reversed order through a valid/ready output stage.
// Optional: define BITREV_READER_ERR_EN to add sticky err_ovf / err_pt flags.
module bitrev_reorder_reader #(
    parameter  int DATA_WIDTH = 32,
    parameter  int MAX_POINT  = 64,
    localparam int LOGN       = $clog2(MAX_POINT),
    localparam int PW         = $clog2(LOGN + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [PW-1:0]         point,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  push,
    output logic                  full,
    output logic                  empty,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    output logic                  out_last,
    input  logic                  out_ready
`ifdef BITREV_READER_ERR_EN
    ,
    output logic                  err_ovf,
    output logic                  err_pt
`endif
);

    logic [DATA_WIDTH-1:0] mem [2][MAX_POINT];
    logic [DATA_WIDTH-1:0] rdata [2];
    logic [1:0]            readable, readable_nxt;
    logic [PW-1:0]         bank_point [2];
    logic                  wr_bank, rd_bank, rd_sel;
    logic [LOGN-1:0]       wr_cnt, rd_cnt, rev, rd_addr;
    logic [PW-1:0]         wr_pt, rd_pt;
    logic                  wr_acc, wr_last, rd_en, rd_last, pt_bad;

    // Illegal frame sizes fall back to the largest frame.
    function automatic logic [PW-1:0] clamp_pt(input logic [PW-1:0] p);
        if (p == '0 || int'(p) > LOGN) return PW'(LOGN);
        return p;
    endfunction

    // Index of the last sample of a 2^p frame.
    function automatic logic [LOGN-1:0] last_idx(input logic [PW-1:0] p);
        logic [LOGN:0] t;
        t = ((LOGN + 1)'(1) << p) - (LOGN + 1)'(1);
        return t[LOGN-1:0];
    endfunction

    assign full   = readable[wr_bank];
    assign empty  = !readable[rd_bank];
    assign pt_bad = (point == '0) || (int'(point) > LOGN);

    // Write/read control and the bit-reversed read address.
    always_comb begin
        wr_acc  = push && !full;
        wr_pt   = (wr_cnt == '0) ? clamp_pt(point) : bank_point[wr_bank];
        wr_last = (wr_cnt == last_idx(wr_pt));
        rd_en   = !empty && (!out_valid || out_ready);
        rd_pt   = bank_point[rd_bank];
        rd_last = (rd_cnt == last_idx(rd_pt));
        // Reverse all LOGN bits, then drop the bits beyond the frame size;
        // rd_cnt never exceeds the frame, so the upper address bits end up 0.
        rev = '0;
        for (int i = 0; i < LOGN; i++) rev[i] = rd_cnt[LOGN-1-i];
        rd_addr = rev >> (LOGN - int'(rd_pt));
        // Write and read completions always land on different banks.
        readable_nxt = readable;
        if (wr_acc && wr_last) readable_nxt[wr_bank] = 1'b1;
        if (rd_en && rd_last)  readable_nxt[rd_bank] = 1'b0;
    end

    // Sample storage: written in natural order, no reset needed.
    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_bank][wr_cnt] <= data_in;
    end

    // Registered bank read; a bank not being read keeps its last word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata[0] <= '0;
            rdata[1] <= '0;
        end else if (rd_en) begin
            rdata[rd_bank] <= mem[rd_bank][rd_addr];
        end
    end

    assign out_data = rdata[rd_sel];

    // Bank ownership, counters and the output handshake stage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            readable      <= '0;
            wr_bank       <= 1'b0;
            rd_bank       <= 1'b0;
            rd_sel        <= 1'b0;
            wr_cnt        <= '0;
            rd_cnt        <= '0;
            bank_point[0] <= PW'(LOGN);
            bank_point[1] <= PW'(LOGN);
            out_valid     <= 1'b0;
            out_last      <= 1'b0;
        end else begin
            readable <= readable_nxt;
            if (wr_acc) begin
                if (wr_cnt == '0) bank_point[wr_bank] <= wr_pt;
                if (wr_last) begin
                    wr_cnt  <= '0;
                    wr_bank <= ~wr_bank;
                end else begin
                    wr_cnt <= wr_cnt + LOGN'(1);
                end
            end
            if (rd_en) begin
                rd_sel    <= rd_bank;
                out_valid <= 1'b1;
                out_last  <= rd_last;
                if (rd_last) begin
                    rd_cnt  <= '0;
                    rd_bank <= ~rd_bank;
                end else begin
                    rd_cnt <= rd_cnt + LOGN'(1);
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

`ifdef BITREV_READER_ERR_EN
    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_ovf <= 1'b0;
            err_pt  <= 1'b0;
        end else begin
            if (push && full) err_ovf <= 1'b1;
            if (wr_acc && wr_cnt == '0 && pt_bad) err_pt <= 1'b1;
        end
    end
`else
    logic unused_pt_bad;
    assign unused_pt_bad = pt_bad;
`endif

endmodule

// File: tb/tb_bitrev_reorder_reader.sv
// Self-checking bench for bitrev_reorder_reader (MAX_POINT=8): a frame-level
// reference model plus directed scenarios with literal expectations.
module tb_bitrev_reorder_reader;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    point = 2'd3;
    logic [DW-1:0] data_in = '0;
    logic          push = 1'b0;
    logic          full, empty, out_valid, out_last;
    logic [DW-1:0] out_data;
    logic          out_ready = 1'b1;
`ifdef BITREV_READER_ERR_EN
    logic          err_ovf, err_pt;
`endif

    bitrev_reorder_reader #(.DATA_WIDTH(DW), .MAX_POINT(8)) dut (
        .clk(clk), .rst_n(rst_n), .point(point), .data_in(data_in),
        .push(push), .full(full), .empty(empty), .out_data(out_data),
        .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready)
`ifdef BITREV_READER_ERR_EN
        , .err_ovf(err_ovf), .err_pt(err_pt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame length implied by a point value; out-of-range means 8 samples.
    function automatic int plen(input int p);
        if (p == 0 || p > 3) return 8;
        return 1 << p;
    endfunction

    // Bit-reverse i within a frame of len samples.
    function automatic int brev(input int i, input int len);
        int bits = 0;
        int r = 0;
        while ((1 << bits) < len) bits++;
        for (int k = 0; k < bits; k++) if (((i >> k) & 1) != 0) r |= 1 << (bits - 1 - k);
        return r;
    endfunction

    // Reference model: complete frames waiting to be read (at most two),
    // the frame being filled, and the single-entry output stage.
    logic [DW-1:0] hq[$];
    int            lq[$];
    logic [DW-1:0] wq[$];
    int            wlen = 8;
    int            ridx = 0;
    logic          m_ov = 0, m_ol = 0;
    logic [DW-1:0] m_od = '0;
    logic          m_ren, m_pacc;

    always @(posedge clk) begin
        if (!rst_n) begin
            hq.delete(); lq.delete(); wq.delete();
            ridx = 0; m_ov = 0; m_ol = 0; m_od = '0;
        end else begin
            m_ren  = (lq.size() > 0) && (!m_ov || out_ready);
            m_pacc = push && (lq.size() < 2);
            if (m_ren) begin
                int len;
                len  = lq[0];
                m_od = hq[brev(ridx, len)];
                m_ol = (ridx == len - 1);
                m_ov = 1'b1;
                ridx++;
                if (m_ol) begin
                    for (int k = 0; k < len; k++) void'(hq.pop_front());
                    void'(lq.pop_front());
                    ridx = 0;
                end
            end else if (out_ready) begin
                m_ov = 1'b0;
            end
            if (m_pacc) begin
                if (wq.size() == 0) wlen = plen(int'(point));
                wq.push_back(data_in);
                if (wq.size() == wlen) begin
                    foreach (wq[k]) hq.push_back(wq[k]);
                    lq.push_back(wlen);
                    wq.delete();
                end
            end
        end
    end

    // Compare process: checks every cycle once out of reset, captures
    // accepted samples, and checks that stalled samples stay put.
    logic          chk_en = 0;
    logic          prev_hold = 0;
    logic [DW-1:0] prev_data = '0;
    logic [DW-1:0] cap_d[$];
    logic          cap_l[$];

    always @(negedge clk) begin
        if (chk_en) begin
            chk("out_valid", DW'(out_valid), DW'(m_ov));
            chk("full", DW'(full), DW'(lq.size() == 2));
            chk("empty", DW'(empty), DW'(lq.size() == 0));
            if (m_ov) begin
                chk("out_data", out_data, m_od);
                chk("out_last", DW'(out_last), DW'(m_ol));
            end
            if (prev_hold) begin
                chk("hold_valid", DW'(out_valid), 1);
                chk("hold_data", out_data, prev_data);
            end
            prev_hold = out_valid && !out_ready;
            prev_data = out_data;
            if (out_valid && out_ready) begin
                cap_d.push_back(out_data);
                cap_l.push_back(out_last);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cap(input int n);
        int k = 0;
        while (cap_d.size() < n && k < 300) begin
            cyc();
            k++;
        end
        chk("cap_count", DW'(cap_d.size()), DW'(n));
    endtask

    int e8[8] = '{0, 4, 2, 6, 1, 5, 3, 7};
    int e4[4] = '{0, 2, 1, 3};

    initial begin
        cyc();
        chk_en = 1;
        rst_n  = 1'b1;
        // Reset values.
        chk("rst_full", DW'(full), 0);
        chk("rst_empty", DW'(empty), 1);
        chk("rst_valid", DW'(out_valid), 0);
        chk("rst_last", DW'(out_last), 0);
        chk("rst_data", out_data, 0);

        // One 8-point frame, consumer always ready.
        point = 2'd3;
        for (int i = 0; i < 8; i++) begin
            push = 1'b1; data_in = DW'(i); cyc();
        end
        push = 1'b0;
        @(negedge clk); chk("lat_first", DW'(out_valid), 0);
        @(negedge clk); chk("lat_second", DW'(out_valid), 1);
        cyc();
        wait_cap(8);
        for (int i = 0; i < 8 && i < cap_d.size(); i++) begin
            chk("f8_data", cap_d[i], DW'(e8[i]));
            chk("f8_last", DW'(cap_l[i]), DW'(i == 7));
        end

        // Two 4-point frames back to back; reads keep pace so no full.
        cap_d.delete(); cap_l.delete();
        point = 2'd2;
        for (int i = 0; i < 8; i++) begin
            push = 1'b1; data_in = DW'((i < 4) ? 10 + i : 16 + i); cyc();
            chk("b2b_full", DW'(full), 0);
        end
        push = 1'b0;
        wait_cap(8);
        for (int i = 0; i < 8 && i < cap_d.size(); i++) begin
            chk("f4_data", cap_d[i], DW'(((i < 4) ? 10 : 20) + e4[i % 4]));
            chk("f4_last", DW'(cap_l[i]), DW'(i % 4 == 3));
        end

        // Consumer stalled: both banks fill, 17th push is dropped.
        cap_d.delete(); cap_l.delete();
        out_ready = 1'b0; point = 2'd3;
        for (int i = 0; i < 16; i++) begin
            push = 1'b1; data_in = DW'(100 + i); cyc();
        end
        chk("stall_full", DW'(full), 1);
        data_in = DW'(999); cyc();
        push = 1'b0;
`ifdef BITREV_READER_ERR_EN
        chk("err_ovf", DW'(err_ovf), 1);
`endif
        out_ready = 1'b1;
        wait_cap(16);
        repeat (5) cyc();
        chk("stall_count", DW'(cap_d.size()), 16);
        chk("stall_empty", DW'(empty), 1);
        for (int i = 0; i < 16 && i < cap_d.size(); i++)
            chk("stall_data", cap_d[i], DW'(100 + 8 * (i / 8) + e8[i % 8]));

        // Ready toggling every cycle mid-frame.
        for (int i = 0; i < 8; i++) begin
            push = 1'b1; data_in = $urandom; cyc();
        end
        push = 1'b0;
        for (int i = 0; i < 30; i++) begin
            out_ready = ~out_ready; cyc();
        end
        out_ready = 1'b1;
        repeat (12) cyc();

        // Reset in the middle of a partial frame.
        for (int i = 0; i < 5; i++) begin
            push = 1'b1; data_in = DW'(50 + i); cyc();
        end
        push = 1'b0; rst_n = 1'b0; cyc();
        rst_n = 1'b1;
        chk("mid_rst_full", DW'(full), 0);
        chk("mid_rst_empty", DW'(empty), 1);
        chk("mid_rst_valid", DW'(out_valid), 0);
        chk("mid_rst_data", out_data, 0);
`ifdef BITREV_READER_ERR_EN
        chk("err_ovf_rst", DW'(err_ovf), 0);
`endif
        cap_d.delete(); cap_l.delete();
        point = 2'd1;
        push = 1'b1; data_in = DW'(7); cyc();
        data_in = DW'(9); cyc();
        push = 1'b0;
        wait_cap(2);
        if (cap_d.size() >= 2) begin
            chk("p1_data0", cap_d[0], 7);
            chk("p1_data1", cap_d[1], 9);
            chk("p1_last1", DW'(cap_l[1]), 1);
        end

        // Randomized traffic including illegal point=0 (clamped to 8 samples).
        for (int i = 0; i < 3000; i++) begin
            push      = ($urandom % 4) != 0;
            data_in   = $urandom;
            point     = 2'($urandom % 4);
            out_ready = ($urandom % 3) != 0;
            cyc();
        end
        push = 1'b0; out_ready = 1'b1;
        repeat (40) cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
